systolic_input_skewer: RTL and testbench

//  Upstream feeder for a row of processing elements. Accepts one N-lane

---
 rtl/systolic_input_skewer.sv | 157 +++++++++++++++
 tb/tb_systolic_input_skewer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_skewer.sv
`default_nettype none
// ============================================================================
// Module : systolic_input_skewer
// Buffers N-lane vectors in a FIFO and emits them diagonally skewed to a PE row.
// Rev    : 1.0  initial release
// ============================================================================
module systolic_input_skewer #(
   parameter int N     = 4,
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   input  logic            in_last,
   output logic [N*DW-1:0] out_data,
   output logic [N-1:0]    out_valid,
   output logic            busy,
   output logic            done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(N + 1);
   localparam int EW = N*DW + 1;

   localparam logic [AW:0]   C_FULL       = (AW+1)'(DEPTH);
   localparam logic [AW:0]   C_CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] C_PTR_ONE    = AW'(1);
   localparam logic [CW-1:0] C_DRAIN_INIT = CW'(N - 1);
   localparam logic [CW-1:0] C_DRAIN_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2
   } state_t;

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_drain_cnt;
   logic [CW-1:0] w_drain_nxt;
   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_head;
   logic          w_head_last;
   logic [N-1:0]  r_last_pipe;

   // Ready depends on occupancy only, so a full FIFO never accepts even when popping.
   assign in_ready    = (r_count != C_FULL);
   assign w_push      = in_valid & in_ready;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_last = w_head[EW-1];
   assign busy        = (r_state != S_IDLE) || (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_last, in_data};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         if (w_push && !w_pop)      r_count <= r_count + C_CNT_ONE;
         else if (!w_push && w_pop) r_count <= r_count - C_CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain_cnt;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE, S_STREAM: begin
            if (r_count != '0) begin
               w_pop = 1'b1;
               if (w_head_last) begin
                  // Hold off the next tile until the last vector clears lane N-1.
                  if (N > 1) begin
                     w_state_nxt = S_DRAIN;
                     w_drain_nxt = C_DRAIN_INIT;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_state_nxt = S_STREAM;
               end
            end
         end
         S_DRAIN: begin
            w_drain_nxt = r_drain_cnt - C_DRAIN_ONE;
            if (r_drain_cnt == C_DRAIN_ONE) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Lane i is a chain of i+1 stages; non-pop cycles inject a zero bubble.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] r_d [0:gi];
      logic [gi:0]   r_v;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int s = 0; s <= gi; s++) r_d[s] <= '0;
            r_v <= '0;
         end else begin
            r_d[0] <= w_pop ? w_head[gi*DW +: DW] : '0;
            r_v[0] <= w_pop;
            for (int s = 1; s <= gi; s++) begin
               r_d[s] <= r_d[s-1];
               r_v[s] <= r_v[s-1];
            end
         end
      end

      assign out_data[gi*DW +: DW] = r_d[gi];
      assign out_valid[gi]         = r_v[gi];
   end

   // The last tag rides alongside lane N-1 so done lines up with its final beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_pipe <= '0;
      end else begin
         r_last_pipe[0] <= w_pop & w_head_last;
         for (int s = 1; s < N; s++) r_last_pipe[s] <= r_last_pipe[s-1];
      end
   end

   assign done = r_last_pipe[N-1];

endmodule
`default_nettype wire

// File: tb/tb_systolic_input_skewer.sv
`default_nettype none
// ============================================================================
// Module : tb_systolic_input_skewer
// Directed bench for systolic_input_skewer (N=4 instance plus an N=1 instance).
// Rev    : 1.0  initial release
// ============================================================================
module tb_systolic_input_skewer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic [31:0] out_data;
   logic [3:0]  out_valid;
   logic        busy;
   logic        done;

   logic        d1_valid;
   logic        d1_ready;
   logic [7:0]  d1_data;
   logic        d1_last;
   logic [7:0]  d1_out_data;
   logic [0:0]  d1_out_valid;
   logic        d1_busy;
   logic        d1_done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int b;

   int          ex_edge [$];
   logic [31:0] ex_vec  [$];
   bit          ex_last [$];

   systolic_input_skewer #(.N(4), .DW(8), .DEPTH(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_data  (out_data),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   systolic_input_skewer #(.N(1), .DW(8), .DEPTH(4)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (d1_valid),
      .in_ready  (d1_ready),
      .in_data   (d1_data),
      .in_last   (d1_last),
      .out_data  (d1_out_data),
      .out_valid (d1_out_valid),
      .busy      (d1_busy),
      .done      (d1_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic expect_pop(input int edge_no, input logic [31:0] vec, input bit last);
      ex_edge.push_back(edge_no);
      ex_vec.push_back(vec);
      ex_last.push_back(last);
   endtask

   // Lane i shows a vector popped at edge p in the cycle after edge p+i.
   task automatic compare_cycle();
      logic [3:0]  ev;
      logic [31:0] ed;
      logic        edn;
      logic [31:0] v;
      ev  = '0;
      ed  = '0;
      edn = 1'b0;
      foreach (ex_edge[k]) begin
         v = ex_vec[k];
         for (int i = 0; i < 4; i++) begin
            if (cyc == ex_edge[k] + i) begin
               ev[i]          = 1'b1;
               ed[i*8 +: 8]   = v[i*8 +: 8];
               if (i == 3 && ex_last[k]) edn = 1'b1;
            end
         end
      end
      check($sformatf("valid@%0d", cyc), {28'd0, out_valid}, {28'd0, ev});
      check($sformatf("data@%0d", cyc), out_data, ed);
      check($sformatf("done@%0d", cyc), {31'd0, done}, {31'd0, edn});
   endtask

   task automatic step(input logic v, input logic l, input logic [31:0] d);
      in_valid = v;
      in_last  = l;
      in_data  = d;
      tick();
      compare_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      d1_valid = 1'b0;
      d1_last  = 1'b0;
      d1_data  = '0;

      // reset values
      #3;
      check("rst_ready",  {31'd0, in_ready}, 32'd1);
      check("rst_busy",   {31'd0, busy},     32'd0);
      check("rst_valid",  {28'd0, out_valid}, 32'd0);
      check("rst_data",   out_data,          32'd0);
      check("rst_done",   {31'd0, done},     32'd0);
      check("rst1_ready", {31'd0, d1_ready}, 32'd1);
      check("rst1_valid", {31'd0, d1_out_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
      idle(2);

      // single vector
      b = cyc;
      expect_pop(b + 2, 32'h04030201, 1'b1);
      step(1'b1, 1'b1, 32'h04030201);
      check("single_busy", {31'd0, busy}, 32'd1);
      idle(7);
      check("single_idle", {31'd0, busy}, 32'd0);

      // streaming: 8 vectors back to back
      b = cyc;
      for (int k = 0; k < 8; k++) begin
         logic [31:0] vec;
         vec = {8'((k+1)*16 + 3), 8'((k+1)*16 + 2), 8'((k+1)*16 + 1), 8'((k+1)*16)};
         expect_pop(b + 2 + k, vec, k == 7);
         check($sformatf("stream_ready%0d", k), {31'd0, in_ready}, 32'd1);
         step(1'b1, k == 7, vec);
      end
      idle(6);

      // backpressure: fill the FIFO while draining
      b = cyc;
      expect_pop(b + 2,  32'hA3A2A1A0, 1'b1);
      expect_pop(b + 6,  32'hB3B2B1B0, 1'b0);
      expect_pop(b + 7,  32'hC3C2C1C0, 1'b0);
      expect_pop(b + 8,  32'hD3D2D1D0, 1'b0);
      expect_pop(b + 9,  32'hE3E2E1E0, 1'b0);
      expect_pop(b + 10, 32'hF3F2F1F0, 1'b1);
      step(1'b1, 1'b1, 32'hA3A2A1A0);
      step(1'b1, 1'b0, 32'hB3B2B1B0);
      step(1'b1, 1'b0, 32'hC3C2C1C0);
      step(1'b1, 1'b0, 32'hD3D2D1D0);
      check("bp_ready_pre", {31'd0, in_ready}, 32'd1);
      step(1'b1, 1'b0, 32'hE3E2E1E0);
      check("bp_ready_full", {31'd0, in_ready}, 32'd0);
      check("bp_busy_full",  {31'd0, busy},     32'd1);
      step(1'b1, 1'b1, 32'hF3F2F1F0);
      check("bp_ready_free", {31'd0, in_ready}, 32'd1);
      step(1'b1, 1'b1, 32'hF3F2F1F0);
      idle(8);

      // gap between beats injects a diagonal bubble
      b = cyc;
      expect_pop(b + 2, 32'h44332211, 1'b0);
      expect_pop(b + 4, 32'h88776655, 1'b1);
      step(1'b1, 1'b0, 32'h44332211);
      step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h88776655);
      idle(6);

      // N=1 instance: done coincides with the only lane, no drain phase
      d1_valid = 1'b1;
      d1_last  = 1'b1;
      d1_data  = 8'hA5;
      tick();
      d1_valid = 1'b0;
      d1_last  = 1'b0;
      d1_data  = '0;
      check("n1_busy_q",   {31'd0, d1_busy},      32'd1);
      check("n1_early",    {31'd0, d1_out_valid}, 32'd0);
      tick();
      check("n1_valid",    {31'd0, d1_out_valid}, 32'd1);
      check("n1_data",     {24'd0, d1_out_data},  32'hA5);
      check("n1_done",     {31'd0, d1_done},      32'd1);
      check("n1_busy_out", {31'd0, d1_busy},      32'd0);
      tick();
      check("n1_valid_off", {31'd0, d1_out_valid}, 32'd0);
      check("n1_data_off",  {24'd0, d1_out_data},  32'h0);
      check("n1_done_off",  {31'd0, d1_done},      32'd0);
      ex_edge.delete();
      ex_vec.delete();
      ex_last.delete();
      idle(2);

      // asynchronous reset mid-tile with three vectors buffered
      b = cyc;
      expect_pop(b + 2, 32'h5A5B5C5D, 1'b1);
      step(1'b1, 1'b1, 32'h5A5B5C5D);
      step(1'b1, 1'b0, 32'h11111111);
      step(1'b1, 1'b0, 32'h22222222);
      step(1'b1, 1'b0, 32'h33333333);
      check("mid_busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid", {28'd0, out_valid}, 32'd0);
      check("arst_data",  out_data,           32'd0);
      check("arst_done",  {31'd0, done},      32'd0);
      check("arst_ready", {31'd0, in_ready},  32'd1);
      check("arst_busy",  {31'd0, busy},      32'd0);
      rst = 1'b1;
      ex_edge.delete();
      ex_vec.delete();
      ex_last.delete();
      idle(6);
      check("post_rst_busy", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
